// File: rtl/word_assembler.sv
`default_nettype none
// ============================================================================
//  Module      : word_assembler
//  Description : Packs a stream of DATA_W-bit beats into one LANES*DATA_W-bit
//                word. An internal lane counter selects the lane for each beat.
//                Both sides use valid/ready handshakes. in_last closes a short
//                word early. While a word is being handed over, a new beat can
//                be accepted in the same cycle, so the stream has no bubbles.
//  Revision    : 1.0  initial release
// ============================================================================
module word_assembler #(
   parameter int DATA_W    = 8,
   parameter int LANES     = 2,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [DATA_W-1:0]            in_data,
   input  logic                         in_last,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [DATA_W*LANES-1:0]      out_data,
   output logic [$clog2(LANES+1)-1:0]   out_count
);

   // Lane index needs at least one bit, even when LANES==1.
   localparam int c_idx_w  = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int c_cnt_w  = $clog2(LANES + 1);
   localparam int c_word_w = DATA_W * LANES;

   localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(LANES - 1);

   // FILL collects beats. HOLD presents a completed word.
   localparam logic [0:0] c_st_fill = 1'b0;
   localparam logic [0:0] c_st_hold = 1'b1;

   logic [0:0]          r_state;
   logic [0:0]          w_state_next;
   logic [c_idx_w-1:0]  r_idx;
   logic [c_word_w-1:0] r_data;
   logic [c_cnt_w-1:0]  r_count;

   logic                w_accept;
   logic                w_take;
   logic                w_close;
   logic [c_idx_w-1:0]  w_idx_eff;
   logic [c_word_w-1:0] w_data_next;

   // A beat can only be accepted in HOLD when the held word drains in the
   // same cycle. That beat starts a fresh word, so its effective lane is 0.
   assign w_accept  = in_valid & in_ready;
   assign w_take    = out_valid & out_ready;
   assign w_idx_eff = (r_state == c_st_hold) ? '0 : r_idx;
   assign w_close   = w_accept & ((w_idx_eff == c_last_idx) | in_last);

   // Next word contents, built one lane at a time. A beat landing during
   // HOLD starts a fresh word, so every other lane is zeroed.
   for (genvar k = 0; k < LANES; k++) begin : g_lane
      localparam int c_lsb = MSB_FIRST ? (LANES - 1 - k) * DATA_W : k * DATA_W;
      logic w_lane_sel;
      assign w_lane_sel = (w_idx_eff == c_idx_w'(k));
      assign w_data_next[c_lsb +: DATA_W] =
         w_lane_sel               ? in_data :
         (r_state == c_st_hold)   ? {DATA_W{1'b0}} :
                                    r_data[c_lsb +: DATA_W];
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= c_st_fill;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic. In HOLD, a take with a word-closing beat stays in HOLD.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         c_st_fill: begin
            if (w_close) begin
               w_state_next = c_st_hold;
            end
         end
         c_st_hold: begin
            if (w_take) begin
               w_state_next = w_close ? c_st_hold : c_st_fill;
            end
         end
         default: begin
            w_state_next = c_st_fill;
         end
      endcase
   end

   // Handshake outputs. In HOLD, input readiness follows the consumer.
   always_comb begin
      out_valid = 1'b0;
      in_ready  = 1'b1;
      case (r_state)
         c_st_fill: begin
            out_valid = 1'b0;
            in_ready  = 1'b1;
         end
         c_st_hold: begin
            out_valid = 1'b1;
            in_ready  = out_ready;
         end
         default: begin
            out_valid = 1'b0;
            in_ready  = 1'b1;
         end
      endcase
   end

   // Datapath: lane index, word register and filled-lane count.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_idx   <= '0;
         r_data  <= '0;
         r_count <= '0;
      end else if (w_accept) begin
         r_data <= w_data_next;
         if (w_close) begin
            r_idx   <= '0;
            r_count <= c_cnt_w'(w_idx_eff) + c_cnt_w'(1);
         end else begin
            r_idx   <= w_idx_eff + c_idx_w'(1);
            r_count <= '0;
         end
      end else if (w_take) begin
         r_idx   <= '0;
         r_data  <= '0;
         r_count <= '0;
      end
   end

   assign out_data  = r_data;
   assign out_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_word_assembler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_word_assembler
//  Description : Drives three word_assembler instances from one shared beat
//                stream. The instances are 4 lanes MSB-first, 2 lanes
//                LSB-first and 2 lanes MSB-first. Each instance is compared
//                with a word-level reference model kept in the bench.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_word_assembler;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       in_last = 1'b0;
   logic       out_ready = 1'b0;

   logic        ir0, ir1, ir2;
   logic        ov0, ov1, ov2;
   logic [31:0] od0;
   logic [15:0] od1, od2;
   logic [2:0]  oc0;
   logic [1:0]  oc1, oc2;

   int total = 0;
   int bad   = 0;

   // Reference model state, one entry per instance.
   logic [7:0]  part [3][4];
   int          part_n [3];
   logic        hv [3];
   logic [31:0] hw [3];
   int          hc [3];

   word_assembler #(.DATA_W(8), .LANES(4), .MSB_FIRST(1'b1)) u_d0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir0), .in_data(in_data),
      .in_last(in_last), .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .out_count(oc0));

   word_assembler #(.DATA_W(8), .LANES(2), .MSB_FIRST(1'b0)) u_d1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1), .in_data(in_data),
      .in_last(in_last), .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .out_count(oc1));

   word_assembler #(.DATA_W(8), .LANES(2), .MSB_FIRST(1'b1)) u_d2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir2), .in_data(in_data),
      .in_last(in_last), .out_valid(ov2), .out_ready(out_ready), .out_data(od2), .out_count(oc2));

   always #5 clk = ~clk;

   function automatic int lanes_of(int d);
      return (d == 0) ? 4 : 2;
   endfunction

   function automatic bit msb_of(int d);
      return (d == 1) ? 1'b0 : 1'b1;
   endfunction

   // Assemble the collected beats: beat i goes to lane i.
   function automatic logic [31:0] pack(int d);
      logic [31:0] w;
      w = 32'h0;
      for (int i = 0; i < part_n[d]; i++) begin
         int sh;
         sh = msb_of(d) ? (lanes_of(d) - 1 - i) * 8 : i * 8;
         w = w | (32'(part[d][i]) << sh);
      end
      return w;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic check_dut(input int d, input logic ov, input logic ir,
                            input logic [31:0] odat, input logic [31:0] ocnt);
      chk($sformatf("d%0d out_valid", d), 32'(ov), 32'(hv[d]));
      chk($sformatf("d%0d in_ready", d), 32'(ir), 32'(!hv[d] || out_ready));
      if (hv[d]) begin
         chk($sformatf("d%0d out_data", d), odat, hw[d]);
         chk($sformatf("d%0d out_count", d), ocnt, 32'(hc[d]));
      end
   endtask

   task automatic clear_model();
      for (int d = 0; d < 3; d++) begin
         part_n[d] = 0;
         hv[d]     = 1'b0;
         hw[d]     = 32'h0;
         hc[d]     = 0;
      end
   endtask

   // One clock cycle: apply inputs, check outputs, advance the model.
   // The task is entered and left at a falling edge.
   task automatic cycle(input logic v, input logic [7:0] dat, input logic l, input logic r);
      in_valid  = v;
      in_data   = dat;
      in_last   = l;
      out_ready = r;
      #1;
      check_dut(0, ov0, ir0, od0, 32'(oc0));
      check_dut(1, ov1, ir1, 32'(od1), 32'(oc1));
      check_dut(2, ov2, ir2, 32'(od2), 32'(oc2));
      for (int d = 0; d < 3; d++) begin
         bit rdy;
         bit take;
         bit acc;
         rdy  = !hv[d] || r;
         take = hv[d] && r;
         acc  = v && rdy;
         if (take) hv[d] = 1'b0;
         if (acc) begin
            part[d][part_n[d]] = dat;
            part_n[d]++;
            if (part_n[d] == lanes_of(d) || l) begin
               hw[d]     = pack(d);
               hc[d]     = part_n[d];
               hv[d]     = 1'b1;
               part_n[d] = 0;
            end
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      in_valid  = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b0;
      rst       = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      clear_model();
      #1;
      chk("rst out_valid", {ov2, ov1, ov0}, 32'h0);
      chk("rst in_ready", {ir2, ir1, ir0}, 32'h7);
      chk("rst d0 data", od0, 32'h0);
      chk("rst d1d2 data", {od2, od1}, 32'h0);
      chk("rst count", {oc2, oc1, oc0}, 32'h0);
   endtask

   initial begin
      clear_model();
      @(negedge clk);
      do_reset();

      // Two lanes, both lane orders.
      cycle(1'b1, 8'hA5, 1'b0, 1'b1);
      cycle(1'b1, 8'h3C, 1'b0, 1'b1);
      chk("t1 d2 valid", 32'(ov2), 32'h1);
      chk("t1 d2 data", 32'(od2), 32'hA53C);
      chk("t1 d2 count", 32'(oc2), 32'h2);
      chk("t2 d1 data", 32'(od1), 32'h3CA5);

      // Short word on the 4-lane instance.
      do_reset();
      cycle(1'b1, 8'h11, 1'b0, 1'b1);
      cycle(1'b1, 8'h22, 1'b1, 1'b1);
      chk("t3 d0 data", od0, 32'h11220000);
      chk("t3 d0 count", 32'(oc0), 32'h2);

      // A stalled consumer back-pressures, then the word drains with a new beat.
      do_reset();
      cycle(1'b1, 8'h12, 1'b0, 1'b0);
      cycle(1'b1, 8'h34, 1'b0, 1'b0);
      cycle(1'b1, 8'h56, 1'b0, 1'b0);
      chk("t4 d2 held", 32'(od2), 32'h1234);
      chk("t4 d2 stall ready", 32'(ir2), 32'h0);
      cycle(1'b1, 8'h56, 1'b0, 1'b1);
      cycle(1'b1, 8'h78, 1'b0, 1'b1);
      chk("t4 d2 next", 32'(od2), 32'h5678);

      // Continuous stream with no bubbles.
      do_reset();
      for (int i = 1; i <= 8; i++) begin
         cycle(1'b1, 8'(i), 1'b0, 1'b1);
         if (i == 4) chk("t5 word0", od0, 32'h01020304);
         if (i == 8) chk("t5 word1", od0, 32'h05060708);
      end

      // A partial word is discarded by reset.
      do_reset();
      cycle(1'b1, 8'hAA, 1'b0, 1'b1);
      cycle(1'b1, 8'hBB, 1'b0, 1'b1);
      do_reset();
      for (int i = 1; i <= 4; i++) cycle(1'b1, 8'(i), 1'b0, 1'b1);
      chk("t6 word", od0, 32'h01020304);

      // Randomized traffic.
      repeat (3000) begin
         cycle($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 9) < 2,
               $urandom_range(0, 9) < 6);
      end
      repeat (4) cycle(1'b0, 8'h00, 1'b0, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
